// File: rtl/serial_pattern_matcher_pkg.sv
// serial_pattern_matcher_pkg
//   Shared constants for the serial pattern matcher family:
//   - legal PATTERN_WIDTH range
//   - fill-counter width helper
//   - default pattern and mask values used by the matcher and its benches
package serial_pattern_matcher_pkg;

    localparam int MIN_PATTERN_WIDTH = 2;
    localparam int MAX_PATTERN_WIDTH = 32;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;
    localparam logic [3:0] DEFAULT_MASK    = 4'b1111;

    // The fill counter must be able to hold the value PATTERN_WIDTH itself.
    function automatic int fill_width(input int pattern_width);
        return $clog2(pattern_width + 1);
    endfunction

endpackage

// File: rtl/serial_pattern_matcher_sat_counter.sv
// sat_counter
//   Saturating event counter with a sticky overflow flag.
//   Ports:
//     clk       in   rising-edge clock
//     n_reset   in   asynchronous active-low reset
//     inc       in   count one event on this edge
//     clr       in   synchronous clear of count and overflow
//     count     out  WIDTH-bit saturating count
//     overflow  out  sticky; set when an event arrives with count at all ones
//   A clear coinciding with an event leaves count at 1 so that event is kept.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= inc ? WIDTH'(1) : '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                overflow <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/serial_pattern_matcher.sv
// serial_pattern_matcher
//   Compares the most recent PATTERN_WIDTH sampled bits against a
//   run-time-loadable pattern and don't-care mask. Emits a one-cycle match
//   pulse and counts matches in a saturating counter.
//   Ports:
//     clk          in   rising-edge clock
//     n_reset      in   asynchronous active-low reset
//     in_bit       in   serial data bit
//     in_valid     in   sample in_bit on this edge
//     cfg_load     in   load cfg_pattern / cfg_mask (discards in_bit this edge)
//     cfg_pattern  in   new pattern, MSB is the oldest bit in time
//     cfg_mask     in   new mask, 1 = bit must match, 0 = don't care
//     clear_count  in   synchronous clear of match_count and overflow
//     match        out  one-cycle match pulse, 1 clock after the completing bit
//     match_count  out  saturating match count
//     overflow     out  sticky counter overflow
//     primed       out  history holds PATTERN_WIDTH valid bits
//
//   Input handshake: in_valid is a qualifier only, there is no back-pressure.
//   Every edge with in_valid=1 and cfg_load=0 consumes in_bit; an edge with
//   in_valid=0 leaves history, fill and count untouched.
module serial_pattern_matcher
    import serial_pattern_matcher_pkg::*;
#(
    parameter int                       PATTERN_WIDTH = 4,
    parameter logic [PATTERN_WIDTH-1:0] RESET_PATTERN = PATTERN_WIDTH'(DEFAULT_PATTERN),
    parameter logic [PATTERN_WIDTH-1:0] RESET_MASK    = {PATTERN_WIDTH{1'b1}},
    parameter bit                       OVERLAP       = 1'b1,
    parameter int                       COUNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     in_bit,
    input  logic                     in_valid,
    input  logic                     cfg_load,
    input  logic [PATTERN_WIDTH-1:0] cfg_pattern,
    input  logic [PATTERN_WIDTH-1:0] cfg_mask,
    input  logic                     clear_count,
    output logic                     match,
    output logic [COUNT_WIDTH-1:0]   match_count,
    output logic                     overflow,
    output logic                     primed
);

    localparam int FILL_W = fill_width(PATTERN_WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX    = FILL_W'(PATTERN_WIDTH);
    localparam logic [FILL_W-1:0] FILL_BEFORE = FILL_W'(PATTERN_WIDTH - 1);

    // Out-of-range widths fail elaboration by referencing a module that
    // does not exist.
    if (PATTERN_WIDTH < MIN_PATTERN_WIDTH || PATTERN_WIDTH > MAX_PATTERN_WIDTH) begin : g_bad_width
        illegal_pattern_width_parameter u_illegal ();
    end

    logic [PATTERN_WIDTH-1:0] history;
    logic [PATTERN_WIDTH-1:0] pattern;
    logic [PATTERN_WIDTH-1:0] mask;
    logic [FILL_W-1:0]        fill;

    logic                     sample;
    logic [PATTERN_WIDTH-1:0] next_hist;
    logic [FILL_W-1:0]        fill_inc;
    logic                     hit;

    always_comb begin
        sample    = in_valid && !cfg_load;
        next_hist = {history[PATTERN_WIDTH-2:0], in_bit};
        fill_inc  = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
        // The incoming bit completes a full window when fill+1 >= PATTERN_WIDTH.
        hit       = sample && (fill >= FILL_BEFORE) &&
                    (((next_hist ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            history <= '0;
            fill    <= '0;
            pattern <= RESET_PATTERN;
            mask    <= RESET_MASK;
            match   <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            mask    <= cfg_mask;
            fill    <= '0;
            match   <= 1'b0;
        end else if (in_valid) begin
            history <= next_hist;
            match   <= hit;
            // Non-overlap mode restarts the fill but keeps the history bits;
            // they can no longer contribute because fill gates the compare.
            if (hit && !OVERLAP) begin
                fill <= '0;
            end else begin
                fill <= fill_inc;
            end
        end else begin
            match <= 1'b0;
        end
    end

    assign primed = (fill == FILL_MAX);

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_count (
        .clk      (clk),
        .n_reset  (n_reset),
        .inc      (hit),
        .clr      (clear_count),
        .count    (match_count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_serial_pattern_matcher.sv
// tb_serial_pattern_matcher
//   Directed bench for serial_pattern_matcher. Three instances share all
//   inputs: a (defaults, overlap), b (OVERLAP=0), c (COUNT_WIDTH=2).
module tb_serial_pattern_matcher;
    import serial_pattern_matcher_pkg::*;

    logic       clk;
    logic       n_reset;
    logic       in_bit;
    logic       in_valid;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [3:0] cfg_mask;
    logic       clear_count;

    logic       match_a, ovf_a, primed_a;
    logic [7:0] count_a;
    logic       match_b, ovf_b, primed_b;
    logic [7:0] count_b;
    logic       match_c, ovf_c, primed_c;
    logic [1:0] count_c;

    int n_assert = 0;
    int n_fail   = 0;

    serial_pattern_matcher u_a (
        .clk(clk), .n_reset(n_reset), .in_bit(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .clear_count(clear_count), .match(match_a), .match_count(count_a),
        .overflow(ovf_a), .primed(primed_a)
    );

    serial_pattern_matcher #(.OVERLAP(1'b0)) u_b (
        .clk(clk), .n_reset(n_reset), .in_bit(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .clear_count(clear_count), .match(match_b), .match_count(count_b),
        .overflow(ovf_b), .primed(primed_b)
    );

    serial_pattern_matcher #(.COUNT_WIDTH(2)) u_c (
        .clk(clk), .n_reset(n_reset), .in_bit(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .clear_count(clear_count), .match(match_c), .match_count(count_c),
        .overflow(ovf_c), .primed(primed_c)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, outputs are sampled
    // 1 time unit after the rising edge.
    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic send_bit(input logic b, input logic clr);
        @(negedge clk);
        in_valid    = 1'b1;
        in_bit      = b;
        clear_count = clr;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        clear_count = 1'b0;
    endtask

    task automatic idle_cycle(input logic clr);
        @(negedge clk);
        clear_count = clr;
        @(posedge clk);
        #1;
        clear_count = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] pat, input logic [3:0] msk, input logic b);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_mask    = msk;
        in_valid    = 1'b1;
        in_bit      = b;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [0:6] s1   = 7'b1001001;
    logic [0:6] e1_a = 7'b0001001;
    logic [0:6] e1_b = 7'b0001000;
    logic [0:9] s2   = 10'b1110001001;
    logic [0:9] e2   = 10'b0000000001;
    logic [0:7] s3   = 8'b01100010;
    logic [0:7] e3   = 8'b00010001;
    logic [0:5] s5   = 6'b011001;
    logic [0:5] e5   = 6'b000001;

    initial begin
        n_reset     = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_mask    = '0;
        clear_count = 1'b0;

        // Reset state
        #3;
        chk("rst_match_a", 32'(match_a), 32'd0);
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_primed_a", 32'(primed_a), 32'd0);
        chk("rst_count_c", 32'(count_c), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;

        // Stream 1001001: overlap matches at bits 4 and 7, non-overlap only at 4
        for (int i = 0; i < 7; i++) begin
            send_bit(s1[i], 1'b0);
            chk($sformatf("s1_match_a[%0d]", i + 1), 32'(match_a), 32'(e1_a[i]));
            chk($sformatf("s1_match_b[%0d]", i + 1), 32'(match_b), 32'(e1_b[i]));
            if (i == 2) begin
                chk("s1_primed_a_bit3", 32'(primed_a), 32'd0);
            end
            if (i == 3) begin
                chk("s1_primed_a_bit4", 32'(primed_a), 32'd1);
                chk("s1_primed_b_bit4", 32'(primed_b), 32'd0);
            end
        end
        chk("s1_count_a", 32'(count_a), 32'd2);
        chk("s1_count_b", 32'(count_b), 32'd1);
        chk("s1_primed_b_end", 32'(primed_b), 32'd0);

        // Stream with a 3-cycle gap after bit 5: one match at bit 10
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_bit(s2[i], 1'b0);
            chk($sformatf("s2_match_a[%0d]", i + 1), 32'(match_a), 32'(e2[i]));
            if (i == 4) begin
                for (int k = 0; k < 3; k++) begin
                    idle_cycle(1'b0);
                    chk($sformatf("s2_idle_match_a[%0d]", k), 32'(match_a), 32'd0);
                end
            end
        end
        chk("s2_count_a", 32'(count_a), 32'd1);

        // Saturating 2-bit counter with an all-zero mask
        do_reset();
        do_load(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b0);
            chk($sformatf("c_unprimed_match[%0d]", i + 1), 32'(match_c), 32'd0);
        end
        send_bit(1'b0, 1'b0);
        chk("c_match_bit4", 32'(match_c), 32'd1);
        chk("c_count_1", 32'(count_c), 32'd1);
        send_bit(1'b1, 1'b0);
        chk("c_count_2", 32'(count_c), 32'd2);
        send_bit(1'b0, 1'b0);
        chk("c_count_3", 32'(count_c), 32'd3);
        chk("c_ovf_before", 32'(ovf_c), 32'd0);
        send_bit(1'b1, 1'b0);
        chk("c_count_sat", 32'(count_c), 32'd3);
        chk("c_ovf_set", 32'(ovf_c), 32'd1);
        send_bit(1'b0, 1'b1);
        chk("c_clr_hit_match", 32'(match_c), 32'd1);
        chk("c_clr_hit_count", 32'(count_c), 32'd1);
        chk("c_clr_hit_ovf", 32'(ovf_c), 32'd0);
        send_bit(1'b1, 1'b0);
        chk("c_after_clr_count", 32'(count_c), 32'd2);
        idle_cycle(1'b1);
        chk("c_clr_idle_count", 32'(count_c), 32'd0);
        chk("c_clr_idle_match", 32'(match_c), 32'd0);

        // Reload while fill=3; old zeros must not complete a window
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0, 1'b0);
        end
        do_load(4'b0110, 4'b1001, 1'b0);
        chk("s3_load_match", 32'(match_a), 32'd0);
        chk("s3_load_primed", 32'(primed_a), 32'd0);
        chk("s3_load_count", 32'(count_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_bit(s3[i], 1'b0);
            chk($sformatf("s3_match_a[%0d]", i + 1), 32'(match_a), 32'(e3[i]));
        end
        chk("s3_count_a", 32'(count_a), 32'd2);

        // Asynchronous reset mid-stream, then default pattern must be back
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("s5_count_pre", 32'(count_a), 32'd2);
        #2;
        n_reset = 1'b0;
        #1;
        chk("s5_async_count", 32'(count_a), 32'd0);
        chk("s5_async_primed", 32'(primed_a), 32'd0);
        chk("s5_async_match", 32'(match_a), 32'd0);
        chk("s5_async_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_bit(s5[i], 1'b0);
            chk($sformatf("s5_match_a[%0d]", i + 1), 32'(match_a), 32'(e5[i]));
        end
        chk("s5_count_a", 32'(count_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
